// File: rtl/pfft_div_pkg.sv
// Shared types and default widths for the posit FFT unsigned divider.
// The divider top takes its parameter defaults from here.
package pfft_div_pkg;

  localparam int DIVIDEND_W = 61;
  localparam int DIVISOR_W  = 4;
  localparam int QUOT_W     = DIVIDEND_W - DIVISOR_W;
  localparam int REM_W      = DIVISOR_W + 1;
  localparam int DIV_ITER   = DIVIDEND_W;
  localparam int CNT_W      = $clog2(DIV_ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/pfft_udiv_step.sv
// One radix-2 restoring division step.
// Shifts the next dividend bit into the partial remainder, then subtracts the divisor when it fits.
module pfft_udiv_step #(
  parameter int DIVISOR_WIDTH = 4
) (
  input  logic [DIVISOR_WIDTH:0]   rem,
  input  logic                     next_bit,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   new_rem,
  output logic                     q_bit
);

  localparam int REM_WIDTH = DIVISOR_WIDTH + 1;

  logic [REM_WIDTH:0]   trial;
  logic [REM_WIDTH-1:0] sub;

  assign trial = {rem, next_bit};
  assign q_bit = trial >= {{(REM_WIDTH + 1 - DIVISOR_WIDTH){1'b0}}, divisor};
  assign sub   = q_bit ? {1'b0, divisor} : '0;

  // The remainder stays below the divisor, so the top trial bit drops out of the modular subtraction.
  assign new_rem = trial[REM_WIDTH-1:0] - sub;

endmodule

// File: rtl/pfft_udiv_61ns_4ns_57.sv
// Sequential 61/4-bit unsigned restoring divider, one quotient bit per cycle.
// It has valid/ready handshakes on both sides. Results stay registered until the consumer takes them.
module pfft_udiv_61ns_4ns_57
  import pfft_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W,
  parameter int QUOT_WIDTH     = DIVIDEND_WIDTH - DIVISOR_WIDTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOT_WIDTH-1:0]     quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      ovf,
  output logic                      dbz
);

  localparam int REM_WIDTH = DIVISOR_WIDTH + 1;
  localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

  state_t state, state_next;

  logic [DIVIDEND_WIDTH-1:0] shift_reg;
  logic [DIVIDEND_WIDTH-1:0] quot_reg;
  logic [REM_WIDTH-1:0]      rem_reg;
  logic [REM_WIDTH-1:0]      step_rem;
  logic [DIVISOR_WIDTH-1:0]  divisor_reg;
  logic [CNT_WIDTH-1:0]      iter_cnt;
  logic                      dbz_reg;
  logic                      step_bit;
  logic                      accept;
  logic                      last_iter;

  assign accept    = in_valid && in_ready;
  assign last_iter = (iter_cnt == LAST_ITER);

  pfft_udiv_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .rem      (rem_reg),
    .next_bit (shift_reg[DIVIDEND_WIDTH-1]),
    .divisor  (divisor_reg),
    .new_rem  (step_rem),
    .q_bit    (step_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
      end
      CALC: if (last_iter) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the working registers double as the output registers, so they are reset to give all-zero outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      shift_reg   <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      iter_cnt    <= '0;
      dbz_reg     <= 1'b0;
    end else if (accept) begin
      shift_reg   <= dividend;
      divisor_reg <= divisor;
      iter_cnt    <= '0;
      if (divisor == '0) begin
        quot_reg <= '1;
        rem_reg  <= {1'b0, dividend[DIVISOR_WIDTH-1:0]};
        dbz_reg  <= 1'b1;
      end else begin
        quot_reg <= '0;
        rem_reg  <= '0;
        dbz_reg  <= 1'b0;
      end
    end else if (state == CALC) begin
      shift_reg <= shift_reg << 1;
      rem_reg   <= step_rem;
      quot_reg  <= {quot_reg[DIVIDEND_WIDTH-2:0], step_bit};
      iter_cnt  <= iter_cnt + 1'b1;
    end
  end

  // Holding registers only change on accept or in CALC, so results stay stable in DONE and IDLE.
  assign quotient  = quot_reg[QUOT_WIDTH-1:0];
  assign remainder = rem_reg[DIVISOR_WIDTH-1:0];
  assign ovf       = !dbz_reg && (|quot_reg[DIVIDEND_WIDTH-1:QUOT_WIDTH]);
  assign dbz       = dbz_reg;

endmodule
